// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring divider for the EX stage.
// Signed or unsigned divide, one quotient bit per cycle (MSB first).
// Divide-by-zero and signed overflow complete without iterating.
// stall holds the pipeline from the request cycle until the result is ready.
module div_unit #(
    parameter int unsigned BIT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [BIT_WIDTH-1:0] dividend,
    input  logic [BIT_WIDTH-1:0] divisor,
    output logic [BIT_WIDTH-1:0] quotient,
    output logic [BIT_WIDTH-1:0] remainder,
    output logic                 busy,
    output logic                 done,
    output logic                 stall
);

    localparam int unsigned CW = $clog2(BIT_WIDTH) + 1;
    localparam logic [BIT_WIDTH-1:0] MOST_NEG = {1'b1, {(BIT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [CW-1:0]        cnt;
    // Dividend magnitude shifts out of the top while quotient bits shift in
    // at the bottom, so one register serves both.
    logic [BIT_WIDTH-1:0] acc_q;
    logic [BIT_WIDTH-1:0] part_r;
    logic [BIT_WIDTH-1:0] dvs_mag;
    logic                 sgn_mode;
    logic                 neg_q;
    logic                 neg_r;

    logic                 a_neg;
    logic                 b_neg;
    logic [BIT_WIDTH-1:0] a_mag;
    logic [BIT_WIDTH-1:0] b_mag;
    logic                 div_zero;
    logic                 sgn_ovf;
    logic                 special;

    logic [BIT_WIDTH:0]   shifted;
    logic [BIT_WIDTH:0]   diff;
    logic                 fits;
    logic [BIT_WIDTH-1:0] part_nx;
    logic [BIT_WIDTH-1:0] acc_nx;
    logic                 last;
    logic [BIT_WIDTH-1:0] q_fix;
    logic [BIT_WIDTH-1:0] r_fix;

    // Operand conditioning at request time: magnitudes, signs and special cases.
    always_comb begin
        a_neg    = is_signed & dividend[BIT_WIDTH-1];
        b_neg    = is_signed & divisor[BIT_WIDTH-1];
        a_mag    = a_neg ? -dividend : dividend;
        b_mag    = b_neg ? -divisor : divisor;
        div_zero = (divisor == '0);
        sgn_ovf  = is_signed & (dividend == MOST_NEG) & (divisor == '1);
        special  = div_zero | sgn_ovf;
    end

    // One restoring step plus sign correction of the final step's result.
    always_comb begin
        shifted = {part_r, acc_q[BIT_WIDTH-1]};
        diff    = shifted - {1'b0, dvs_mag};
        fits    = ~diff[BIT_WIDTH];
        part_nx = fits ? diff[BIT_WIDTH-1:0] : shifted[BIT_WIDTH-1:0];
        acc_nx  = {acc_q[BIT_WIDTH-2:0], fits};
        last    = (cnt == '0);
        q_fix   = (sgn_mode & neg_q) ? -acc_nx : acc_nx;
        r_fix   = (sgn_mode & neg_r) ? -part_nx : part_nx;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode and pipeline stall.
    always_comb begin
        state_nx = state;
        stall    = 1'b0;
        case (state)
            IDLE: begin
                stall = start;
                if (start) begin
                    state_nx = special ? DONE : RUN;
                end
            end
            RUN: begin
                stall = 1'b1;
                if (last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        if (reset) begin
            stall = 1'b0;
        end
    end

    // Datapath: latch operands on accept, iterate in RUN, write results at the end.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            acc_q     <= '0;
            part_r    <= '0;
            dvs_mag   <= '0;
            sgn_mode  <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            busy <= (state_nx == RUN);
            done <= (state_nx == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        sgn_mode <= is_signed;
                        neg_q    <= a_neg ^ b_neg;
                        neg_r    <= a_neg;
                        acc_q    <= a_mag;
                        dvs_mag  <= b_mag;
                        part_r   <= '0;
                        cnt      <= CW'(BIT_WIDTH - 1);
                        if (div_zero) begin
                            quotient  <= '1;
                            remainder <= dividend;
                        end else if (sgn_ovf) begin
                            quotient  <= dividend;
                            remainder <= '0;
                        end
                    end
                end
                RUN: begin
                    part_r <= part_nx;
                    acc_q  <= acc_nx;
                    cnt    <= cnt - CW'(1);
                    if (last) begin
                        quotient  <= q_fix;
                        remainder <= r_fix;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed vector table, hand-written corner sequences and
// random operations checked against an arithmetic reference model.
module tb_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        busy;
    logic        done;
    logic        stall;

    int total;
    int bad;

    div_unit #(.BIT_WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .stall     (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sg;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference: plain SV arithmetic plus the two special cases.
    function automatic logic [63:0] model(input logic sg, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic signed [31:0] qs;
        logic signed [31:0] rs;
        if (b == 32'h0) return {32'hFFFF_FFFF, a};
        if (sg) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {a, 32'h0};
            sa = a;
            sb = b;
            qs = sa / sb;
            rs = sa % sb;
            return {qs, rs};
        end
        return {a / b, a % b};
    endfunction

    function automatic int model_lat(input logic sg, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'h0) return 1;
        if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one divide from IDLE; inputs are scrambled after acceptance.
    task automatic run_op(input string nm, input logic sg, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er, input int elat);
        int lat;
        int stall_cnt;
        int busy_cnt;
        logic got;
        lat = 0;
        stall_cnt = 0;
        busy_cnt = 0;
        got = 1'b0;
        start = 1'b1;
        is_signed = sg;
        dividend = a;
        divisor = b;
        #1;
        if (stall) stall_cnt++;
        for (int c = 1; c <= 100 && !got; c++) begin
            tick();
            start = 1'b0;
            is_signed = 1'($urandom);
            dividend = $urandom;
            divisor = $urandom;
            #1;
            if (busy) busy_cnt++;
            if (done) begin
                got = 1'b1;
                lat = c;
            end else if (stall) begin
                stall_cnt++;
            end
        end
        chk({nm, "_latency"}, 32'(lat), 32'(elat));
        chk({nm, "_stall_cycles"}, 32'(stall_cnt), 32'(elat));
        chk({nm, "_busy_cycles"}, 32'(busy_cnt), 32'(elat - 1));
        chk({nm, "_quotient"}, quotient, eq);
        chk({nm, "_remainder"}, remainder, er);
        tick();
        chk({nm, "_done_one_cycle"}, 32'(done), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] m;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        int          first_done;
        int          second_done;
        int          dones;

        total = 0;
        bad = 0;

        tbl[0] = '{1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         33};
        tbl[1] = '{1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 33};
        tbl[2] = '{1'b0, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC, 32'd1,         33};
        tbl[3] = '{1'b0, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5,         1};
        tbl[4] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         1};
        tbl[5] = '{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 33};
        tbl[6] = '{1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         33};
        tbl[7] = '{1'b1, 32'hFFFF_FFF6, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFF6, 1};
        tbl[8] = '{1'b0, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'd0,         33};
        tbl[9] = '{1'b1, 32'h8000_0000, 32'd1,         32'h8000_0000, 32'd0,         33};

        // Reset with a request pending: reset wins, stall forced low.
        reset = 1'b1;
        start = 1'b1;
        is_signed = 1'b0;
        dividend = 32'd5;
        divisor = 32'd0;
        tick();
        tick();
        #1;
        chk("reset_stall", 32'(stall), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_quotient", quotient, 32'd0);
        chk("reset_remainder", remainder, 32'd0);
        reset = 1'b0;
        start = 1'b0;
        tick();
        chk("reset_no_accept", 32'(done), 32'd0);

        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), tbl[i].sg, tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].lat);
        end

        // Reset on RUN cycle 10 aborts without writing a result.
        start = 1'b1;
        is_signed = 1'b0;
        dividend = 32'd1000;
        divisor = 32'd3;
        for (int c = 1; c <= 10; c++) begin
            tick();
            start = 1'b0;
        end
        chk("abort_pre_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_stall_in_reset", 32'(stall), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_stall", 32'(stall), 32'd0);
        chk("abort_quotient", quotient, 32'd0);
        chk("abort_remainder", remainder, 32'd0);
        run_op("after_abort", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 33);

        // start held high through DONE, operands changed mid-RUN.
        start = 1'b1;
        is_signed = 1'b0;
        dividend = 32'hDEAD_BEEF;
        divisor = 32'h0000_1234;
        first_done = 0;
        second_done = 0;
        dones = 0;
        for (int c = 1; c <= 80; c++) begin
            tick();
            if (c == 5) begin
                is_signed = 1'b1;
                dividend = 32'hFFFF_FF9C;
                divisor = 32'd7;
            end
            #1;
            if (done) begin
                dones++;
                if (first_done == 0) begin
                    first_done = c;
                    m = model(1'b0, 32'hDEAD_BEEF, 32'h0000_1234);
                    chk("held_first_quotient", quotient, m[63:32]);
                    chk("held_first_remainder", remainder, m[31:0]);
                    chk("held_done_stall", 32'(stall), 32'd0);
                end else if (second_done == 0) begin
                    second_done = c;
                    m = model(1'b1, 32'hFFFF_FF9C, 32'd7);
                    chk("held_second_quotient", quotient, m[63:32]);
                    chk("held_second_remainder", remainder, m[31:0]);
                    start = 1'b0;
                end
            end
            if (first_done != 0 && c == first_done + 1) chk("held_reaccept_stall", 32'(stall), 32'd1);
            if (first_done != 0 && c == first_done + 2) chk("held_reaccept_busy", 32'(busy), 32'd1);
        end
        chk("held_first_cycle", 32'(first_done), 32'd33);
        chk("held_second_cycle", 32'(second_done), 32'd67);
        chk("held_done_pulses", 32'(dones), 32'd2);
        start = 1'b0;
        tick();

        // Random operations against the reference model.
        for (int n = 0; n < 40; n++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: begin
                    rs = 1'b1;
                    ra = 32'h8000_0000;
                    rb = 32'hFFFF_FFFF;
                end
                3: rb = rb >> $urandom_range(0, 31);
                default: ;
            endcase
            m = model(rs, ra, rb);
            run_op($sformatf("rnd%0d", n), rs, ra, rb, m[63:32], m[31:0], model_lat(rs, ra, rb));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
